// File: rtl/div_unit.sv
// div_unit: iterative RV32M DIV/DIVU/REM/REMU unit writing back through a register file port.
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, op         request (sampled in IDLE) and operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1_val, rs2_val  dividend and divisor from the register file read ports
//   rd_addr           destination register index
//   busy, done        busy from accept through DONE; one-cycle completion pulse
//   we, wa, wd        register file write port (we suppressed for x0)
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_addr,
    output logic            busy,
    output logic            done,
    output logic            we,
    output logic [4:0]      wa,
    output logic [XLEN-1:0] wd
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;
    logic [XLEN:0]   rem, rem_nx;
    logic [XLEN-1:0] quo, quo_nx, dvs, abs_a, abs_b, sp_q, sp_r, q_fin, r_fin;
    logic [XLEN+1:0] shifted, diff;
    logic [5:0]      cnt;
    logic            is_rem, neg_q, neg_r, sgn, ovf, special, last;
    always_comb begin
        sgn     = !op[0];
        abs_a   = sgn && rs1_val[XLEN-1] ? -rs1_val : rs1_val;
        abs_b   = sgn && rs2_val[XLEN-1] ? -rs2_val : rs2_val;
        ovf     = sgn && rs1_val == {1'b1, {(XLEN-1){1'b0}}} && rs2_val == '1;
        special = rs2_val == '0 || ovf;
        sp_q    = ovf ? {1'b1, {(XLEN-1){1'b0}}} : '1;
        sp_r    = ovf ? '0 : rs1_val;
        // Shift the next dividend bit into the partial remainder and trial-subtract.
        shifted = {rem, quo[XLEN-1]};
        diff    = shifted - {2'b0, dvs};
        rem_nx  = diff[XLEN+1] ? shifted[XLEN:0] : diff[XLEN:0];
        quo_nx  = {quo[XLEN-2:0], ~diff[XLEN+1]};
        q_fin   = neg_q ? -quo_nx : quo_nx;
        r_fin   = neg_r ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];
        last    = cnt == 6'(XLEN-1);
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? (special ? DONE : CALC) : IDLE;
            CALC:    state_nx = last ? DONE : CALC;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            done   <= 1'b0;
            we     <= 1'b0;
            wa     <= '0;
            wd     <= '0;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            is_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            done <= 1'b0;
            we   <= 1'b0;
            if (state == IDLE && start) begin
                wa     <= rd_addr;
                is_rem <= op[1];
                neg_q  <= sgn && (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]);
                neg_r  <= sgn && rs1_val[XLEN-1];
                rem    <= '0;
                quo    <= abs_a;
                dvs    <= abs_b;
                cnt    <= '0;
                if (special) begin
                    done <= 1'b1;
                    we   <= rd_addr != 5'd0;
                    wd   <= op[1] ? sp_r : sp_q;
                end
            end else if (state == CALC) begin
                rem <= rem_nx;
                quo <= quo_nx;
                cnt <= cnt + 6'd1;
                if (last) begin
                    done <= 1'b1;
                    we   <= wa != 5'd0;
                    wd   <= is_rem ? r_fin : q_fin;
                end
            end
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized self-checking bench for div_unit against an arithmetic reference model.
module tb_div_unit;
    logic        clk = 0, rst = 1, start = 0;
    logic [1:0]  op = 0;
    logic [31:0] rs1_val = 0, rs2_val = 0;
    logic [4:0]  rd_addr = 0;
    logic        busy, done, we;
    logic [4:0]  wa;
    logic [31:0] wd;
    int n_chk = 0, n_pass = 0;

    div_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .rd_addr(rd_addr), .busy(busy), .done(done), .we(we), .wa(wa), .wd(wd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        logic [31:0] q, r;
        sa = a;
        sb = b;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 0;
        end else if (!o[0]) begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return o[1] ? r : q;
    endfunction

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit poke, input bit full);
        int lat;
        logic [31:0] exp;
        exp = model(o, a, b);
        @(negedge clk);
        op = o; rs1_val = a; rs2_val = b; rd_addr = rd; start = 1;
        @(posedge clk); #1;
        start = 0;
        op = $urandom; rs1_val = $urandom; rs2_val = $urandom; rd_addr = $urandom;
        if (full) chk({tag, ".busy"}, 32'(busy), 1);
        lat = 0;
        while (!done && lat < 40) begin
            start = poke && lat == 4;
            @(posedge clk); #1;
            lat++;
        end
        start = 0;
        chk({tag, ".wd"}, wd, exp);
        if (full) begin
            chk({tag, ".lat"}, lat, is_special(o, a, b) ? 0 : 32);
            chk({tag, ".we"}, 32'(we), 32'(rd != 0));
            chk({tag, ".wa"}, 32'(wa), 32'(rd));
        end
        if (poke) start = 1;
        @(posedge clk); #1;
        start = 0;
        if (full) chk({tag, ".idle"}, {30'd0, busy, done}, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst.out", {busy, done, we, wa}, 0);
        chk("rst.wd", wd, 0);
        rst = 0;
        run("divu", 2'b01, 100, 7, 5, 0, 1);
        run("remu", 2'b11, 100, 7, 5, 0, 1);
        run("div_neg", 2'b00, 32'hFFFF_FFF9, 2, 3, 0, 1);
        run("rem_neg", 2'b10, 32'hFFFF_FFF9, 2, 3, 0, 1);
        run("div_negb", 2'b00, 7, 32'hFFFF_FFFE, 9, 0, 1);
        run("divu_z", 2'b01, 32'h1234, 0, 4, 0, 1);
        run("rem_z", 2'b10, 32'h1234, 0, 4, 0, 1);
        run("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 6, 0, 1);
        run("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 6, 0, 1);
        run("x0", 2'b01, 50, 5, 0, 0, 1);
        run("ignore", 2'b01, 100, 7, 5, 1, 1);
        // Back-to-back special ops: the edge after DONE must accept again.
        @(negedge clk);
        op = 2'b01; rs1_val = 1; rs2_val = 0; rd_addr = 2; start = 1;
        @(posedge clk); #1;
        chk("b2b.d1", 32'(done), 1);
        @(posedge clk); #1;
        chk("b2b.gap", {30'd0, busy, done}, 0);
        rs1_val = 32'h55; rd_addr = 7; op = 2'b11;
        @(posedge clk); #1;
        start = 0;
        chk("b2b.d2", {wd[30:0], done}, {31'h55, 1'b1});
        @(posedge clk); #1;
        // Reset in the middle of CALC aborts without a write.
        @(negedge clk);
        op = 2'b01; rs1_val = 100; rs2_val = 7; rd_addr = 5; start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (10) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("abort.busy", 32'(busy), 0);
        begin
            int pulses;
            pulses = 0;
            repeat (40) begin
                @(posedge clk); #1;
                pulses += int'(done) + int'(we);
            end
            chk("abort.pulses", pulses, 0);
        end
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 20);
                3: b = -$urandom_range(1, 20);
                default: ;
            endcase
            run("rand", 2'($urandom), a, b, 5'($urandom), 0, 1);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
